fc_stream_arbiter: RTL and testbench

Shares one fully connected layer instance (an M-output, N-input matrix-vector engine with valid/ready streams) between two requester channels. The arbiter grants one channel for a complete transaction: N input elements streamed into the layer, then M results streamed back to the same channel. It sits between two upstream producers/consumers and the layer's input_*/output_* ports, and provides round-robin fairness at vector granularity.

---
 rtl/fc_stream_arbiter.sv | 156 +++++++++++++++
 tb/tb_fc_stream_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fc_stream_arbiter.sv
// Two-channel arbiter sharing one fully connected layer at vector granularity.
// Optional build macro: FC_ARB_FIXED_PRIORITY_EN (channel 0 always wins ties).
//
// state  | meaning
// IDLE   | no owner; arbitrate among requesters with valid high
// FEED   | granted channel streams N elements into the layer
// DRAIN  | layer streams M results back to the granted channel
module fc_stream_arbiter #(
  parameter int M = 4,
  parameter int N = 4,
  parameter int T = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [T-1:0] req0_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [T-1:0] req1_data,
  output logic         resp0_valid,
  input  logic         resp0_ready,
  output logic [T-1:0] resp0_data,
  output logic         resp1_valid,
  input  logic         resp1_ready,
  output logic [T-1:0] resp1_data,
  output logic         layer_in_valid,
  input  logic         layer_in_ready,
  output logic [T-1:0] layer_in_data,
  input  logic         layer_out_valid,
  output logic         layer_out_ready,
  input  logic [T-1:0] layer_out_data,
  output logic         grant_id,
  output logic         busy,
  output logic         proto_err
);

  localparam int ICW = (N > 1) ? $clog2(N) : 1;
  localparam int OCW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN} state_t;

  state_t         state_q, state_d;
  logic           grant_q, grant_d;
  logic           last_q, last_d;
  logic [ICW-1:0] in_cnt_q, in_cnt_d;
  logic [OCW-1:0] out_cnt_q, out_cnt_d;
  logic           err_q, err_d;
  logic           in_hs, out_hs;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_d          = last_q;
    in_cnt_d        = in_cnt_q;
    out_cnt_d       = out_cnt_q;
    req0_ready      = 1'b0;
    req1_ready      = 1'b0;
    resp0_valid     = 1'b0;
    resp1_valid     = 1'b0;
    resp0_data      = '0;
    resp1_data      = '0;
    layer_in_valid  = 1'b0;
    layer_in_data   = '0;
    layer_out_ready = 1'b0;
    in_hs           = 1'b0;
    out_hs          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req0_valid | req1_valid) begin
          if (req0_valid & req1_valid) begin
`ifdef FC_ARB_FIXED_PRIORITY_EN
            grant_d = 1'b0;
`else
            grant_d = ~last_q;
`endif
          end else begin
            grant_d = req1_valid;
          end
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = S_FEED;
        end
      end
      S_FEED: begin
        if (grant_q) begin
          layer_in_valid = req1_valid;
          layer_in_data  = req1_data;
          req1_ready     = layer_in_ready;
        end else begin
          layer_in_valid = req0_valid;
          layer_in_data  = req0_data;
          req0_ready     = layer_in_ready;
        end
        in_hs = layer_in_valid & layer_in_ready;
        if (in_hs) begin
          if (in_cnt_q == ICW'(N - 1)) begin
            in_cnt_d = '0;
            state_d  = S_DRAIN;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (grant_q) begin
          resp1_valid     = layer_out_valid;
          resp1_data      = layer_out_data;
          layer_out_ready = resp1_ready;
        end else begin
          resp0_valid     = layer_out_valid;
          resp0_data      = layer_out_data;
          layer_out_ready = resp0_ready;
        end
        out_hs = layer_out_valid & layer_out_ready;
        if (out_hs) begin
          if (out_cnt_q == OCW'(M - 1)) begin
            out_cnt_d = '0;
            last_d    = grant_q;
            state_d   = S_IDLE;
          end else begin
            out_cnt_d = out_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Any result offered by the layer while we are not draining is a protocol breach.
    err_d = err_q | (layer_out_valid & (state_q != S_DRAIN));
  end

  assign grant_id  = grant_q;
  assign busy      = (state_q != S_IDLE);
  assign proto_err = err_q;

endmodule

// File: tb/tb_fc_stream_arbiter.sv
// Directed vector table plus a randomized-stall sequence for fc_stream_arbiter (M=N=4, T=16).
module tb_fc_stream_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [15:0] req0_data, req1_data;
  logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [15:0] resp0_data, resp1_data;
  logic        layer_in_valid, layer_in_ready, layer_out_valid, layer_out_ready;
  logic [15:0] layer_in_data, layer_out_data;
  logic        grant_id, busy, proto_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fc_stream_arbiter #(.M(4), .N(4), .T(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .layer_in_valid(layer_in_valid), .layer_in_ready(layer_in_ready), .layer_in_data(layer_in_data),
    .layer_out_valid(layer_out_valid), .layer_out_ready(layer_out_ready), .layer_out_data(layer_out_data),
    .grant_id(grant_id), .busy(busy), .proto_err(proto_err)
  );

  typedef struct {
    string       name;
    logic        rst, r0v, r1v, p0r, p1r, lir, lov;
    logic [15:0] r0d, r1d, lod;
    logic [56:0] exp_out;
  } vec_t;

  vec_t vecs[$];

  // Expected packing: r0r r1r liv lid p0v p0d p1v p1d lor gid busy err
  task automatic add(input string nm, input logic rst,
                     input logic r0v, input logic [15:0] r0d,
                     input logic r1v, input logic [15:0] r1d,
                     input logic p0r, input logic p1r, input logic lir,
                     input logic lov, input logic [15:0] lod,
                     input logic e_r0r, input logic e_r1r, input logic e_liv, input logic [15:0] e_lid,
                     input logic e_p0v, input logic [15:0] e_p0d,
                     input logic e_p1v, input logic [15:0] e_p1d,
                     input logic e_lor, input logic e_gid, input logic e_busy, input logic e_err);
    vec_t v;
    v.name = nm; v.rst = rst; v.r0v = r0v; v.r0d = r0d; v.r1v = r1v; v.r1d = r1d;
    v.p0r = p0r; v.p1r = p1r; v.lir = lir; v.lov = lov; v.lod = lod;
    v.exp_out = {e_r0r, e_r1r, e_liv, e_lid, e_p0v, e_p0d, e_p1v, e_p1d, e_lor, e_gid, e_busy, e_err};
    vecs.push_back(v);
  endtask

  function automatic logic [56:0] actual_out();
    return {req0_ready, req1_ready, layer_in_valid, layer_in_data, resp0_valid, resp0_data,
            resp1_valid, resp1_data, layer_out_ready, grant_id, busy, proto_err};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    resp0_ready = 1'b0; resp1_ready = 1'b0; layer_in_ready = 1'b0;
    layer_out_valid = 1'b0; layer_out_data = '0;
  endtask

  initial begin
    //   name         rst r0v r0d    r1v r1d    p0r p1r lir lov lod      r0r r1r liv lid    p0v p0d    p1v p1d    lor gid bsy err
    add("reset",      1, 0,16'h0,   0,16'h0,   0,0, 0, 0,16'h0,     0,0,0,16'h0,   0,16'h0,   0,16'h0,   0,0,0,0);
    add("idle_req0",  0, 1,16'h1,   0,16'h0,   0,0, 1, 0,16'h0,     0,0,0,16'h0,   0,16'h0,   0,16'h0,   0,0,0,0);
    add("feed0_e1",   0, 1,16'h1,   0,16'h0,   0,0, 1, 0,16'h0,     1,0,1,16'h1,   0,16'h0,   0,16'h0,   0,0,1,0);
    add("feed0_bp",   0, 1,16'h2,   0,16'h0,   0,0, 0, 0,16'h0,     0,0,1,16'h2,   0,16'h0,   0,16'h0,   0,0,1,0);
    add("feed0_e2",   0, 1,16'h2,   0,16'h0,   0,0, 1, 0,16'h0,     1,0,1,16'h2,   0,16'h0,   0,16'h0,   0,0,1,0);
    add("feed0_gap",  0, 0,16'h0,   0,16'h0,   0,0, 1, 0,16'h0,     1,0,0,16'h0,   0,16'h0,   0,16'h0,   0,0,1,0);
    add("feed0_e3",   0, 1,16'h3,   0,16'h0,   0,0, 1, 0,16'h0,     1,0,1,16'h3,   0,16'h0,   0,16'h0,   0,0,1,0);
    add("feed0_e4",   0, 1,16'h4,   1,16'h99,  0,0, 1, 0,16'h0,     1,0,1,16'h4,   0,16'h0,   0,16'h0,   0,0,1,0);
    add("drain0_r1",  0, 0,16'h0,   1,16'h99,  1,0, 0, 1,16'h10,    0,0,0,16'h0,   1,16'h10,  0,16'h0,   1,0,1,0);
    add("drain0_bp",  0, 0,16'h0,   1,16'h99,  0,0, 0, 1,16'h20,    0,0,0,16'h0,   1,16'h20,  0,16'h0,   0,0,1,0);
    add("drain0_r2",  0, 0,16'h0,   1,16'h99,  1,0, 0, 1,16'h20,    0,0,0,16'h0,   1,16'h20,  0,16'h0,   1,0,1,0);
    add("drain0_gap", 0, 0,16'h0,   1,16'h99,  1,0, 0, 0,16'h0,     0,0,0,16'h0,   0,16'h0,   0,16'h0,   1,0,1,0);
    add("drain0_r3",  0, 0,16'h0,   1,16'h99,  1,0, 0, 1,16'h30,    0,0,0,16'h0,   1,16'h30,  0,16'h0,   1,0,1,0);
    add("drain0_r4",  0, 0,16'h0,   1,16'h99,  1,0, 0, 1,16'hFFF0,  0,0,0,16'h0,   1,16'hFFF0,0,16'h0,   1,0,1,0);
    add("idle_tie1",  0, 1,16'h55,  1,16'h99,  0,0, 1, 0,16'h0,     0,0,0,16'h0,   0,16'h0,   0,16'h0,   0,0,0,0);
    add("feed1_e1",   0, 1,16'h55,  1,16'hA1,  0,0, 1, 0,16'h0,     0,1,1,16'hA1,  0,16'h0,   0,16'h0,   0,1,1,0);
    add("feed1_inj",  0, 1,16'h55,  1,16'hA2,  0,0, 1, 1,16'h77,    0,1,1,16'hA2,  0,16'h0,   0,16'h0,   0,1,1,0);
    add("feed1_e3",   0, 1,16'h55,  1,16'hA3,  0,0, 1, 0,16'h0,     0,1,1,16'hA3,  0,16'h0,   0,16'h0,   0,1,1,1);
    add("feed1_e4",   0, 1,16'h55,  1,16'hA4,  0,0, 1, 0,16'h0,     0,1,1,16'hA4,  0,16'h0,   0,16'h0,   0,1,1,1);
    add("drain1_r1",  0, 0,16'h0,   0,16'h0,   1,1, 0, 1,16'hB1,    0,0,0,16'h0,   0,16'h0,   1,16'hB1,  1,1,1,1);
    add("drain1_r2",  0, 0,16'h0,   0,16'h0,   1,1, 0, 1,16'hB2,    0,0,0,16'h0,   0,16'h0,   1,16'hB2,  1,1,1,1);
    add("drain1_r3",  0, 0,16'h0,   0,16'h0,   1,1, 0, 1,16'hB3,    0,0,0,16'h0,   0,16'h0,   1,16'hB3,  1,1,1,1);
    add("drain1_r4",  0, 0,16'h0,   0,16'h0,   1,1, 0, 1,16'hB4,    0,0,0,16'h0,   0,16'h0,   1,16'hB4,  1,1,1,1);
    add("idle_tie0",  0, 1,16'h11,  1,16'hE1,  0,0, 1, 0,16'h0,     0,0,0,16'h0,   0,16'h0,   0,16'h0,   0,1,0,1);
    add("feed0b_e1",  0, 1,16'h11,  1,16'hE1,  0,0, 1, 0,16'h0,     1,0,1,16'h11,  0,16'h0,   0,16'h0,   0,0,1,1);
    add("feed0b_e2",  0, 1,16'h12,  1,16'hE1,  0,0, 1, 0,16'h0,     1,0,1,16'h12,  0,16'h0,   0,16'h0,   0,0,1,1);
    add("rst_mid",    1, 1,16'h13,  1,16'hE1,  0,0, 1, 0,16'h0,     1,0,1,16'h13,  0,16'h0,   0,16'h0,   0,0,1,1);
    add("post_rst",   0, 0,16'h0,   1,16'hC1,  0,0, 1, 0,16'h0,     0,0,0,16'h0,   0,16'h0,   0,16'h0,   0,0,0,0);
    add("feed1b_e1",  0, 0,16'h0,   1,16'hC1,  0,0, 1, 0,16'h0,     0,1,1,16'hC1,  0,16'h0,   0,16'h0,   0,1,1,0);
    add("feed1b_e2",  0, 0,16'h0,   1,16'hC2,  0,0, 1, 0,16'h0,     0,1,1,16'hC2,  0,16'h0,   0,16'h0,   0,1,1,0);
    add("feed1b_e3",  0, 0,16'h0,   1,16'hC3,  0,0, 1, 0,16'h0,     0,1,1,16'hC3,  0,16'h0,   0,16'h0,   0,1,1,0);
    add("feed1b_e4",  0, 0,16'h0,   1,16'hC4,  0,0, 1, 0,16'h0,     0,1,1,16'hC4,  0,16'h0,   0,16'h0,   0,1,1,0);
    add("drain1b_r1", 0, 0,16'h0,   0,16'h0,   0,1, 0, 1,16'hD1,    0,0,0,16'h0,   0,16'h0,   1,16'hD1,  1,1,1,0);
    add("drain1b_r2", 0, 0,16'h0,   0,16'h0,   0,1, 0, 1,16'hD2,    0,0,0,16'h0,   0,16'h0,   1,16'hD2,  1,1,1,0);
    add("drain1b_r3", 0, 0,16'h0,   0,16'h0,   0,1, 0, 1,16'hD3,    0,0,0,16'h0,   0,16'h0,   1,16'hD3,  1,1,1,0);
    add("drain1b_r4", 0, 0,16'h0,   0,16'h0,   0,1, 0, 1,16'hD4,    0,0,0,16'h0,   0,16'h0,   1,16'hD4,  1,1,1,0);
    add("idle_end",   0, 0,16'h0,   0,16'h0,   0,0, 0, 0,16'h0,     0,0,0,16'h0,   0,16'h0,   0,16'h0,   0,1,0,0);

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst;
      req0_valid = vecs[i].r0v; req0_data = vecs[i].r0d;
      req1_valid = vecs[i].r1v; req1_data = vecs[i].r1d;
      resp0_ready = vecs[i].p0r; resp1_ready = vecs[i].p1r;
      layer_in_ready = vecs[i].lir;
      layer_out_valid = vecs[i].lov; layer_out_data = vecs[i].lod;
      #1;
      check(vecs[i].name, 64'(actual_out()), 64'(vecs[i].exp_out));
    end

    // Randomized stalls on channel 0: exactly 4 elements in, 4 results out, in order.
    begin
      int in_got, out_got, extra_in, resp1_seen, cyc;
      in_got = 0; out_got = 0; extra_in = 0; resp1_seen = 0; cyc = 0;
      idle_inputs();
      while (out_got < 4 && cyc < 400) begin
        @(negedge clk);
        cyc++;
        req0_valid = 1'($urandom_range(0, 1));
        req0_data = 16'h100 + 16'(in_got);
        layer_in_ready = 1'($urandom_range(0, 1));
        resp0_ready = 1'($urandom_range(0, 1));
        layer_out_valid = (in_got == 4) ? 1'($urandom_range(0, 1)) : 1'b0;
        layer_out_data = 16'h200 + 16'(out_got);
        #1;
        if (resp1_valid) resp1_seen++;
        if (req0_valid && req0_ready) begin
          if (in_got < 4) begin
            check("stall_in_data", 64'(layer_in_data), 64'(16'h100 + 16'(in_got)));
            in_got++;
          end else begin
            extra_in++;
          end
        end
        if (resp0_valid && resp0_ready) begin
          check("stall_out_data", 64'(resp0_data), 64'(16'h200 + 16'(out_got)));
          out_got++;
        end
      end
      check("stall_in_count", 64'(in_got), 64'd4);
      check("stall_out_count", 64'(out_got), 64'd4);
      check("stall_extra_in", 64'(extra_in), 64'd0);
      check("stall_resp1_seen", 64'(resp1_seen), 64'd0);
      @(negedge clk);
      idle_inputs();
      #1;
      check("stall_busy_after", 64'(busy), 64'd0);
      check("stall_err", 64'(proto_err), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
